mem_port_arbiter: RTL and testbench

- Shares one single-port unified SRAM between two requesters:
  - instruction fetch (pc_reg/if_id side);
  - data access (mem stage loads and stores).
- Serialises the accesses with a small FSM and absorbs memory wait states.
- Raises per-requester stall requests that feed ctrl, which freezes the pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2
  } arb_state_e;

  // Wide enough for any TIMEOUT_CYCLES up to 65535.
  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access.
// Optional wait-state timeout enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_sel,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stop_all_req_from_if,
  output logic                stop_all_req_from_mem,
  output logic                bus_error
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e state_r;
  logic       timeout_s;

  assign stop_all_req_from_if  = if_req & ~if_ack;
  assign stop_all_req_from_mem = dm_req & ~dm_ack;

`ifdef MEM_PORT_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt_r;

  // Fires in the busy cycle whose unanswered wait brings the count to TIMEOUT_CYCLES.
  assign timeout_s = (state_r != ARB_IDLE) && !mem_ready &&
                     (wait_cnt_r == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: zero while idle, counts busy cycles without mem_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r == ARB_IDLE) begin
      wait_cnt_r <= '0;
    end else if (!mem_ready) begin
      wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Bus-error pulse accompanies the forced ack of a timed-out access.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_error <= 1'b0;
    end else begin
      bus_error <= timeout_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ARB_IDLE;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          // Data wins a tie: it belongs to the older instruction.
          if (dm_req) begin
            mem_ce    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_sel   <= dm_sel;
            state_r   <= ARB_DM_BUSY;
          end else if (if_req) begin
            mem_ce    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_sel   <= {SEL_W{1'b1}};
            state_r   <= ARB_IF_BUSY;
          end else begin
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
          end
        end
        ARB_IF_BUSY: begin
          if (mem_ready || timeout_s) begin
            if_rdata <= mem_ready ? mem_rdata : '0;
            if_ack   <= 1'b1;
            mem_ce   <= 1'b0;
            mem_we   <= 1'b0;
            state_r  <= ARB_IDLE;
          end else begin
            state_r  <= ARB_IF_BUSY;
          end
        end
        ARB_DM_BUSY: begin
          if (mem_ready || timeout_s) begin
            if (!mem_we) begin
              dm_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_rdata <= dm_rdata;
            end
            dm_ack  <= 1'b1;
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_DM_BUSY;
          end
        end
        default: begin
          mem_ce  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; acks are checked by a monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_ce, mem_we, mem_ready;
  logic [3:0]  mem_sel;
  logic        stop_if, stop_mem, bus_error;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          berr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] resp_data   = 32'h0;
  int          wait_states = 0;
  bit          stuck       = 1'b0;
  bit          idle_noise  = 1'b0;
  int          busy_cnt    = 0;

  assign mem_rdata = resp_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_sel(dm_sel), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stop_all_req_from_if(stop_if), .stop_all_req_from_mem(stop_mem),
    .bus_error(bus_error)
  );

  // Memory responder: mem_ready after wait_states busy cycles, optional noise while idle.
  always @(negedge clk) begin
    if (mem_ce) begin
      mem_ready = (busy_cnt == wait_states) && !stuck;
      busy_cnt  = busy_cnt + 1;
    end else begin
      busy_cnt  = 0;
      mem_ready = idle_noise;
    end
  end

  // Scoreboard monitor: every ack pulse pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack || dm_ack) begin
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b with nothing expected", if_ack, dm_ack);
      end else begin
        e = exp_q.pop_front();
        if ((dm_ack !== e.is_dm) || (if_ack !== !e.is_dm) ||
            ((e.is_dm ? dm_rdata : if_rdata) !== e.rdata) || (bus_error !== e.berr)) begin
          miscompares = miscompares + 1;
          $display("FAIL completion: got if_ack=%0b dm_ack=%0b rdata=%h berr=%0b, want dm=%0b rdata=%h berr=%0b",
                   if_ack, dm_ack, e.is_dm ? dm_rdata : if_rdata, bus_error, e.is_dm, e.rdata, e.berr);
        end
      end
    end else if (bus_error !== 1'b0) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL stray_bus_error: bus_error=%0b without ack", bus_error);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_sel = 4'h0;
    tick(); tick();
    check("rst_mem_ce",   {31'h0, mem_ce}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_acks",     {30'h0, if_ack, dm_ack}, 32'h0);
    reset = 1'b0;
    tick();

    // Fetch only, zero wait.
    if_req = 1'b1; if_addr = 32'h0000_0004; resp_data = 32'h3C01_0101;
    exp_q.push_back('{1'b0, 32'h3C01_0101, 1'b0});
    #1 check("f_stop_if_pre", {31'h0, stop_if}, 32'h1);
    tick();
    check("f_ce_addr_sel", {mem_ce, mem_we, mem_sel, mem_addr[25:0]}, {1'b1, 1'b0, 4'hF, 26'h4});
    check("f_stop_if_busy", {31'h0, stop_if}, 32'h1);
    tick();
    check("f_ack_ce", {30'h0, if_ack, mem_ce}, 32'h2);
    check("f_rdata", if_rdata, 32'h3C01_0101);
    check("f_stop_if_ack", {31'h0, stop_if}, 32'h0);
    if_req = 1'b0;
    tick();
    check("f_ack_one_cycle", {31'h0, if_ack}, 32'h0);

    // Simultaneous: data first, one idle cycle, then fetch.
    if_req = 1'b1; if_addr = 32'h8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    dm_sel = 4'hF; resp_data = 32'hCAFE_0100;
    exp_q.push_back('{1'b1, 32'hCAFE_0100, 1'b0});
    exp_q.push_back('{1'b0, 32'h3C02_0202, 1'b0});
    tick();
    check("s_dm_first_addr", mem_addr, 32'h100);
    tick();
    check("s_dm_ack", {29'h0, dm_ack, if_ack, mem_ce}, 32'h4);
    check("s_stalls", {30'h0, stop_if, stop_mem}, 32'h2);
    dm_req = 1'b0; resp_data = 32'h3C02_0202;
    tick();
    check("s_if_grant", {mem_ce, mem_addr[30:0]}, {1'b1, 31'h8});
    tick();
    check("s_if_ack_2_after", {31'h0, if_ack}, 32'h1);
    if_req = 1'b0;
    tick();

    // Store with three wait states.
    wait_states = 3; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200;
    dm_wdata = 32'hDEAD_BEEF; dm_sel = 4'b0011;
    exp_q.push_back('{1'b1, 32'hCAFE_0100, 1'b0});
    #1 check("w_stop_mem_pre", {31'h0, stop_mem}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w_hold_ctl", {26'h0, mem_ce, mem_we, mem_sel}, {26'h0, 1'b1, 1'b1, 4'b0011});
      check("w_hold_addr", mem_addr, 32'h200);
      check("w_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("w_no_ack_yet", {31'h0, dm_ack}, 32'h0);
    end
    tick();
    check("w_ack", {30'h0, dm_ack, mem_ce}, 32'h2);
    check("w_rdata_kept", dm_rdata, 32'hCAFE_0100);
    dm_req = 1'b0; dm_we = 1'b0; wait_states = 0;
    tick();

`ifdef MEM_PORT_TIMEOUT_EN
    // Load with memory stuck: forced completion after four busy cycles.
    stuck = 1'b1; dm_req = 1'b1; dm_addr = 32'h300; dm_sel = 4'hF;
    exp_q.push_back('{1'b1, 32'h0, 1'b1});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t_waiting", {30'h0, dm_ack, bus_error}, 32'h0);
    end
    tick();
    check("t_abort", {29'h0, dm_ack, bus_error, mem_ce}, 32'h6);
    check("t_rdata_zero", dm_rdata, 32'h0);
    dm_req = 1'b0; stuck = 1'b0;
    tick();
    check("t_idle", {30'h0, mem_ce, bus_error}, 32'h0);
`endif

    // Reset in the second wait cycle of a fetch.
    stuck = 1'b1; if_req = 1'b1; if_addr = 32'hC;
    tick();
    check("r_ce", {31'h0, mem_ce}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("r_cleared", {29'h0, mem_ce, mem_we, if_ack}, 32'h0);
    check("r_addr", mem_addr, 32'h0);
    check("r_rdata", if_rdata | dm_rdata, 32'h0);
    reset = 1'b0; if_req = 1'b0; stuck = 1'b0;

    // Idle noise: mem_ready with no requests must be ignored.
    idle_noise = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("n_idle", {30'h0, mem_ce, if_ack | dm_ack}, 32'h0);
    end
    idle_noise = 1'b0;
    tick();

    check("q_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
